// File: rtl/stack_cmd_ctrl_pkg.sv
// Shared constants, opcodes and FSM encoding for the stack command front-end.
package stack_cmd_ctrl_pkg;

  localparam int unsigned DEF_DATA_W    = 4;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_DB_CYCLES = 16;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned OP_W          = 2;

  localparam logic [OP_W-1:0] OP_PUSH = 2'b00;
  localparam logic [OP_W-1:0] OP_POP  = 2'b01;
  localparam logic [OP_W-1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/stack_cmd_ctrl_btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stable-sample debouncer -> one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned DB_CNT_W = $clog2(DB_CYCLES + 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic                r_rise;
  logic [DB_CNT_W-1:0] r_cnt;

  // Level flips only after DB_CYCLES consecutive differing samples; a matching sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + DB_CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Command stage for the small stack: debounced push/pop requests checked against a shadow count,
// issued one at a time over a valid/ack handshake, with full/empty status and sticky error flags.
module stack_cmd_ctrl
  import stack_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_push,
  input  logic              btn_pop,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              op_ack,
  output logic              op_valid,
  output logic [1:0]        op_code,
  output logic [DATA_W-1:0] op_data,
  output logic [2:0]        count,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_udf
);

  logic w_push_rise;
  logic w_push_level;
  logic w_pop_rise;
  logic w_pop_level;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_push (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_push),
    .level   (w_push_level),
    .rise    (w_push_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pop (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pop),
    .level   (w_pop_level),
    .rise    (w_pop_rise)
  );

  state_t            r_state,    w_state_nxt;
  logic              r_op_valid, w_op_valid_nxt;
  logic [OP_W-1:0]   r_op_code,  w_op_code_nxt;
  logic [DATA_W-1:0] r_op_data,  w_op_data_nxt;
  logic [CNT_W-1:0]  r_count,    w_count_nxt;
  logic              r_err_ovf,  w_err_ovf_nxt;
  logic              r_err_udf,  w_err_udf_nxt;
  logic              w_can_push;
  logic              w_can_pop;

  assign w_can_push = (r_count < CNT_W'(DEPTH));
  assign w_can_pop  = (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op_valid <= 1'b0;
      r_op_code  <= OP_NOP;
      r_op_data  <= '0;
      r_count    <= '0;
      r_err_ovf  <= 1'b0;
      r_err_udf  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_op_code  <= w_op_code_nxt;
      r_op_data  <= w_op_data_nxt;
      r_count    <= w_count_nxt;
      r_err_ovf  <= w_err_ovf_nxt;
      r_err_udf  <= w_err_udf_nxt;
    end
  end

  // Push has priority over a same-cycle pop; edges outside IDLE are dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_valid_nxt = r_op_valid;
    w_op_code_nxt  = r_op_code;
    w_op_data_nxt  = r_op_data;
    w_count_nxt    = r_count;
    w_err_ovf_nxt  = r_err_ovf;
    w_err_udf_nxt  = r_err_udf;
    case (r_state)
      ST_IDLE: begin
        if (w_push_rise) begin
          if (w_can_push) begin
            w_op_valid_nxt = 1'b1;
            w_op_code_nxt  = OP_PUSH;
            w_op_data_nxt  = sw_data;
            w_state_nxt    = ST_ISSUE;
          end else begin
            w_err_ovf_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_REL;
          end
        end else if (w_pop_rise) begin
          if (w_can_pop) begin
            w_op_valid_nxt = 1'b1;
            w_op_code_nxt  = OP_POP;
            w_op_data_nxt  = '0;
            w_state_nxt    = ST_ISSUE;
          end else begin
            w_err_udf_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_REL;
          end
        end
      end
      ST_ISSUE: begin
        if (op_ack) begin
          w_op_valid_nxt = 1'b0;
          w_op_code_nxt  = OP_NOP;
          w_op_data_nxt  = '0;
          w_err_ovf_nxt  = 1'b0;
          w_err_udf_nxt  = 1'b0;
          if (r_op_code == OP_PUSH) begin
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_count_nxt = r_count - CNT_W'(1);
          end
          w_state_nxt = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!w_push_level && !w_pop_level) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign op_valid = r_op_valid;
  assign op_code  = r_op_code;
  assign op_data  = r_op_data;
  assign count    = r_count;
  assign err_ovf  = r_err_ovf;
  assign err_udf  = r_err_udf;
  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed scenarios plus randomized push/pop traffic, checked against a queue-based stack model.
module tb_stack_cmd_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DB    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_push = 1'b0;
  logic       btn_pop = 1'b0;
  logic [3:0] sw_data = 4'h0;
  logic       op_ack = 1'b0;
  logic       op_valid;
  logic [1:0] op_code;
  logic [3:0] op_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       err_ovf;
  logic       err_udf;

  int n_cmp = 0;
  int n_err = 0;
  int n_vrise = 0;
  logic v_prev = 1'b0;

  logic [3:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  stack_cmd_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .btn_push (btn_push),
    .btn_pop  (btn_pop),
    .sw_data  (sw_data),
    .op_ack   (op_ack),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_data  (op_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
  );

  always #5 clk = ~clk;

  // Counts distinct commands offered to the stack.
  always @(posedge clk) begin
    if (op_valid === 1'b1 && v_prev !== 1'b1) n_vrise++;
    v_prev = op_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(mq.size()));
    check({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, "_ovf"},   32'(err_ovf), 32'(m_ovf));
    check({tag, "_udf"},   32'(err_udf), 32'(m_udf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_push = 1'b0;
    btn_pop = 1'b0;
    op_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
  endtask

  // One press: p/q select buttons (push wins), d is switch data, hold_extra keeps the button down
  // after completion, ack_dly is the number of cycles the command waits before op_ack.
  task automatic do_op(input bit p, input bit q, input logic [3:0] d,
                       input int hold_extra, input int ack_dly);
    int  n0;
    int  waited;
    bit  accept;
    logic [1:0] exp_code;
    accept   = p ? (mq.size() < DEPTH) : (mq.size() > 0);
    exp_code = p ? 2'b00 : 2'b01;
    n0 = n_vrise;
    sw_data  = d;
    btn_push = p;
    btn_pop  = q;
    waited = 0;
    while (op_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("issue_valid", 32'(op_valid), 32'(accept));
    if (accept) begin
      check("issue_code", 32'(op_code), 32'(exp_code));
      check("issue_data", 32'(op_data), 32'(p ? d : 4'h0));
      for (int i = 0; i < ack_dly; i++) begin
        sw_data = 4'($urandom);
        @(negedge clk);
        check("hold_valid", 32'(op_valid), 32'd1);
        check("hold_data", 32'(op_data), 32'(p ? d : 4'h0));
      end
      op_ack = 1'b1;
      @(negedge clk);
      op_ack = 1'b0;
      if (p) mq.push_back(d);
      else void'(mq.pop_back());
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check("done_valid", 32'(op_valid), 32'd0);
      check("done_code", 32'(op_code), 32'h3);
      check("done_data", 32'(op_data), 32'h0);
    end else begin
      if (p) m_ovf = 1'b1;
      else   m_udf = 1'b1;
    end
    check_status("after_op");
    repeat (hold_extra) @(negedge clk);
    check("one_cmd", 32'(n_vrise - n0), 32'(accept));
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    for (int i = 0; i < 26; i++) begin
      op_ack = (i == 5);
      @(negedge clk);
    end
    op_ack = 1'b0;
    check("rel_valid", 32'(op_valid), 32'd0);
    check_status("after_rel");
  endtask

  initial begin
    int w;
    int n0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(op_valid), 32'd0);
    check("rst_code", 32'(op_code), 32'h3);
    check("rst_data", 32'(op_data), 32'h0);
    check_status("rst");
    rst = 1'b0;
    @(negedge clk);

    // Reset while a push of A is pending.
    sw_data = 4'hA;
    btn_push = 1'b1;
    w = 0;
    while (op_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("pend_valid", 32'(op_valid), 32'd1);
    check("pend_data", 32'(op_data), 32'hA);
    rst = 1'b1;
    btn_push = 1'b0;
    #1;
    check("arst_valid", 32'(op_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_code", 32'(op_code), 32'h3);
    check_status("arst");
    repeat (30) @(negedge clk);
    check("arst_no_cmd", 32'(op_valid), 32'd0);

    // Bounce never settles long enough to produce an edge.
    n0 = n_vrise;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_push = ~btn_push;
      @(negedge clk);
    end
    btn_push = 1'b0;
    repeat (3) @(negedge clk);
    check("bounce_none", 32'(n_vrise - n0), 32'd0);
    do_op(1'b1, 1'b0, 4'h5, 0, 1);

    // Fill to full, overflow, then one pop.
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(1'b1, 1'b0, 4'(i), 0, i % 3);
    do_op(1'b1, 1'b0, 4'h9, 0, 0);
    do_op(1'b0, 1'b1, 4'h0, 0, 2);

    // Underflow after reset, then simultaneous push+pop.
    do_reset();
    do_op(1'b0, 1'b1, 4'h0, 0, 0);
    do_op(1'b1, 1'b1, 4'h7, 0, 1);

    // Long hold gives one command; a fresh press gives another.
    do_op(1'b1, 1'b0, 4'hC, 200, 2);
    do_op(1'b1, 1'b0, 4'h3, 0, 0);

    for (int k = 0; k < 30; k++) begin
      int  r;
      bit  p;
      bit  q;
      r = int'($urandom_range(0, 9));
      p = (r < 5) || (r == 9);
      q = (r >= 5);
      do_op(p, q, 4'($urandom), 0, int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
